// File: rtl/dds_meas_pkg.sv
// Shared types and constants for the DDS frequency meter.
package dds_meas_pkg;

  // Width of the DDS phase accumulator the frequency word is expressed in.
  localparam int unsigned DdsAccW = 32;

  // Default zero level and hysteresis half-width for 14-bit offset-binary samples.
  localparam int unsigned DefMid  = 8192;
  localparam int unsigned DefHyst = 256;

  typedef enum logic [1:0] {
    StIdle,
    StGate,
    StDone
  } meas_state_e;

endpackage

// File: rtl/schmitt_edge_det.sv
// Input register plus hysteresis comparator; pulses rise_o for one cycle on a
// LOW->HIGH transition of the Schmitt state. Invalid samples hold the state.
module schmitt_edge_det #(
  parameter int unsigned DataW = 14,
  parameter int unsigned Mid   = 8192,
  parameter int unsigned Hyst  = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [DataW-1:0] data_i,
  output logic             valid_o,
  output logic [DataW-1:0] data_o,
  output logic             rise_o
);

  // One extra bit so Mid + Hyst at full scale cannot wrap.
  localparam logic [DataW:0] HiTh = (DataW + 1)'(Mid + Hyst);
  localparam logic [DataW:0] LoTh = (DataW + 1)'(Mid - Hyst);

  logic             valid_q;
  logic [DataW-1:0] data_q;
  logic             high_q, high_d;
  logic             rise;

  // Register the sample and the Schmitt state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      high_q  <= 1'b0;
    end else begin
      valid_q <= valid_i;
      data_q  <= data_i;
      high_q  <= high_d;
    end
  end

  // Hysteresis decision on the registered sample; a rise needs a prior LOW arming.
  always_comb begin
    high_d = high_q;
    rise   = 1'b0;
    if (valid_q) begin
      if (!high_q && ({1'b0, data_q} >= HiTh)) begin
        high_d = 1'b1;
        rise   = 1'b1;
      end else if (high_q && ({1'b0, data_q} <= LoTh)) begin
        high_d = 1'b0;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign rise_o  = rise;

endmodule

// File: rtl/dds_freq_meter.sv
// Counts rising zero crossings over a 2^GateLog2-clock gate and reports the
// count and the equivalent DDS frequency word. Define PEAK_DETECT_EN to add
// per-gate max/min sample tracking; otherwise the peak outputs are tied 0.
module dds_freq_meter
  import dds_meas_pkg::*;
#(
  parameter int unsigned DataW    = 14,
  parameter int unsigned GateLog2 = 20,
  parameter int unsigned Mid      = DefMid,
  parameter int unsigned Hyst     = DefHyst
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                continuous_i,
  input  logic                data_valid_i,
  input  logic [DataW-1:0]    data_i,
  output logic                busy_o,
  output logic                meas_done_o,
  output logic [GateLog2-1:0] cross_cnt_o,
  output logic [DdsAccW-1:0]  fword_est_o,
  output logic                overflow_o,
  output logic [DataW-1:0]    peak_max_o,
  output logic [DataW-1:0]    peak_min_o
);

  localparam int unsigned Shift = DdsAccW - GateLog2;
  localparam logic [GateLog2-1:0] CntOne = {{(GateLog2 - 1){1'b0}}, 1'b1};

  logic             samp_valid;
  logic [DataW-1:0] samp_data;
  logic             rise;

  schmitt_edge_det #(
    .DataW (DataW),
    .Mid   (Mid),
    .Hyst  (Hyst)
  ) u_schmitt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (data_valid_i),
    .data_i  (data_i),
    .valid_o (samp_valid),
    .data_o  (samp_data),
    .rise_o  (rise)
  );

  meas_state_e         state_q;
  logic [GateLog2-1:0] gate_cnt_q;
  logic [GateLog2-1:0] acc_q, acc_nxt;
  logic                acc_ovf_q, acc_ovf_nxt;
  logic                gate_end;
  logic [GateLog2-1:0] cross_cnt_q;
  logic [DdsAccW-1:0]  fword_q;
  logic                ovf_q, meas_done_q, busy_q;

  // Saturating crossing accumulator; the terminal gate cycle still counts.
  always_comb begin
    acc_nxt     = acc_q;
    acc_ovf_nxt = acc_ovf_q;
    gate_end    = (state_q == StGate) && (&gate_cnt_q);
    if ((state_q == StGate) && rise) begin
      if (&acc_q) acc_ovf_nxt = 1'b1;
      else        acc_nxt     = acc_q + CntOne;
    end
  end

  // Gate FSM with registered results; accumulator cleared as results publish.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      gate_cnt_q  <= '0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
      cross_cnt_q <= '0;
      fword_q     <= '0;
      ovf_q       <= 1'b0;
      meas_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      meas_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StGate;
            busy_q     <= 1'b1;
            gate_cnt_q <= '0;
          end
        end
        StGate: begin
          gate_cnt_q <= gate_cnt_q + CntOne;
          acc_q      <= acc_nxt;
          acc_ovf_q  <= acc_ovf_nxt;
          if (gate_end) begin
            state_q     <= StDone;
            cross_cnt_q <= acc_nxt;
            fword_q     <= DdsAccW'(acc_nxt) << Shift;
            ovf_q       <= acc_ovf_nxt;
            meas_done_q <= 1'b1;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
          end
        end
        StDone: begin
          if (continuous_i) begin
            state_q <= StGate;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign meas_done_o = meas_done_q;
  assign cross_cnt_o = cross_cnt_q;
  assign fword_est_o = fword_q;
  assign overflow_o  = ovf_q;

`ifdef PEAK_DETECT_EN
  logic [DataW-1:0] run_max_q, run_min_q, max_nxt, min_nxt;
  logic [DataW-1:0] peak_max_q, peak_min_q;

  // Fold the current valid sample into the running extremes.
  always_comb begin
    max_nxt = run_max_q;
    min_nxt = run_min_q;
    if ((state_q == StGate) && samp_valid) begin
      if (samp_data > run_max_q) max_nxt = samp_data;
      if (samp_data < run_min_q) min_nxt = samp_data;
    end
  end

  // Track extremes during the gate, publish and re-seed at gate end.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_max_q  <= '0;
      run_min_q  <= '1;
      peak_max_q <= '0;
      peak_min_q <= '0;
    end else if (gate_end) begin
      peak_max_q <= max_nxt;
      peak_min_q <= min_nxt;
      run_max_q  <= '0;
      run_min_q  <= '1;
    end else begin
      run_max_q <= max_nxt;
      run_min_q <= min_nxt;
    end
  end

  assign peak_max_o = peak_max_q;
  assign peak_min_o = peak_min_q;
`else
  logic unused_samp;
  assign unused_samp = ^{samp_valid, samp_data};
  assign peak_max_o  = '0;
  assign peak_min_o  = '0;
`endif

endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed bench for dds_freq_meter with a 1024-clock gate. A second instance
// with zero hysteresis shares all inputs for the max-rate / saturation cases.
module tb_dds_freq_meter;

  localparam int unsigned GateLog2 = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        dv = 1'b0;
  logic [13:0] din = '0;

  logic          busy, done, ovf, h_busy, h_done, h_ovf;
  logic [9:0]    cnt, h_cnt;
  logic [31:0]   fword, h_fword;
  logic [13:0]   pmax, pmin, h_pmax, h_pmin;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  int ph = 0;
  int k;

  dds_freq_meter #(.DataW(14), .GateLog2(GateLog2), .Mid(8192), .Hyst(256)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .continuous_i(cont),
    .data_valid_i(dv), .data_i(din), .busy_o(busy), .meas_done_o(done),
    .cross_cnt_o(cnt), .fword_est_o(fword), .overflow_o(ovf),
    .peak_max_o(pmax), .peak_min_o(pmin)
  );

  dds_freq_meter #(.DataW(14), .GateLog2(GateLog2), .Mid(8192), .Hyst(0)) u_dut_h0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .continuous_i(cont),
    .data_valid_i(dv), .data_i(din), .busy_o(h_busy), .meas_done_o(h_done),
    .cross_cnt_o(h_cnt), .fword_est_o(h_fword), .overflow_o(h_ovf),
    .peak_max_o(h_pmax), .peak_min_o(h_pmin)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  // Waveform generator: new sample every falling edge, selected by mode.
  initial forever begin
    @(negedge clk);
    ph = ph + 1;
    dv = 1'b1;
    case (mode)
      1: din = ((ph % 64) < 32) ? 14'd0 : 14'd16383;
      2: din = 14'(8192 - 200 + int'($urandom_range(400)));
      3: din = ph[0] ? 14'd16383 : 14'd0;
      4: begin
        k = ph % 280;
        if (ph[0]) begin
          dv  = 1'b0;
          din = ((ph % 4) == 1) ? 14'd0 : 14'd16383;
        end else begin
          din = (k < 140) ? 14'(1000 + 100 * k) : 14'(15000 - 100 * (k - 140));
        end
      end
      5: din = ph[0] ? 14'd8192 : 14'd8191;
      default: din = 14'd8192;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) required %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle, then wait (bounded) for meas_done; lat counts edges.
  task automatic run_gate(output int lat);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 1100) begin
      tick();
      n++;
    end
    lat = n + 1;
  endtask

  int lat, nd, first;
  int dt[3];

  initial begin
    #12;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_cnt", {22'd0, cnt}, 32'd0);
    check_eq("rst_fword", fword, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
    check_eq("rst_pmax", {18'd0, pmax}, 32'd0);
    check_eq("rst_pmin", {18'd0, pmin}, 32'd0);
    rst_n = 1'b1;

    // Square wave, period 64: 16 crossings per 1024-clock gate.
    mode = 1;
    repeat (100) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("sq_busy_after_start", {31'd0, busy}, 32'd1);
    nd = 0;
    while (!done && nd < 1100) begin
      tick();
      nd++;
    end
    check_eq("sq_latency", nd + 1, 32'd1025);
    check_eq("sq_busy_in_done", {31'd0, busy}, 32'd1);
    check_eq("sq_cnt", {22'd0, cnt}, 32'd16);
    check_eq("sq_fword", fword, 32'h0400_0000);
    check_eq("sq_ovf", {31'd0, ovf}, 32'd0);
    check_eq("sq_h0_cnt", {22'd0, h_cnt}, 32'd16);
    tick();
    check_eq("sq_done_pulse", {31'd0, done}, 32'd0);
    check_eq("sq_busy_idle", {31'd0, busy}, 32'd0);
    check_eq("sq_hold_cnt", {22'd0, cnt}, 32'd16);

    // Noise inside the hysteresis band: no crossings.
    mode = 2;
    repeat (20) tick();
    run_gate(lat);
    check_eq("noise_cnt", {22'd0, cnt}, 32'd0);
    check_eq("noise_fword", fword, 32'd0);
    check_eq("noise_ovf", {31'd0, ovf}, 32'd0);

    // Period-2 full-scale square: maximum crossing rate.
    mode = 3;
    repeat (20) tick();
    run_gate(lat);
    check_eq("p2_cnt", {22'd0, cnt}, 32'd512);
    check_eq("p2_fword", fword, 32'h8000_0000);
    check_eq("p2_ovf", {31'd0, ovf}, 32'd0);
    check_eq("p2_h0_cnt", {22'd0, h_cnt}, 32'd512);
    check_eq("p2_h0_ovf", {31'd0, h_ovf}, 32'd0);

    // 8191/8192 alternation: only the zero-hysteresis instance sees crossings.
    mode = 5;
    repeat (20) tick();
    run_gate(lat);
    check_eq("alt_cnt", {22'd0, cnt}, 32'd0);
    check_eq("alt_h0_cnt", {22'd0, h_cnt}, 32'd512);
    check_eq("alt_h0_ovf", {31'd0, h_ovf}, 32'd0);

    // Start pulsed again mid-gate must be ignored.
    mode = 1;
    repeat (20) tick();
    start = 1'b1;
    tick();
    nd = 0;
    first = 0;
    for (int i = 2; i <= 2100; i++) begin
      start = (i == 300);
      tick();
      if (done) begin
        nd++;
        if (first == 0) first = i;
      end
    end
    start = 1'b0;
    check_eq("restart_ndone", nd, 32'd1);
    check_eq("restart_first", first, 32'd1025);

    // Continuous mode: one result every 1025 clocks.
    cont = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    for (int i = 2; i <= 3075; i++) begin
      tick();
      if (done) begin
        if (nd < 3) dt[nd] = i;
        nd++;
      end
    end
    check_eq("cont_ndone", nd, 32'd3);
    check_eq("cont_t0", dt[0], 32'd1025);
    check_eq("cont_t1", dt[1], 32'd2050);
    check_eq("cont_t2", dt[2], 32'd3075);
    check_eq("cont_cnt", {22'd0, cnt}, 32'd16);
    cont = 1'b0;
    tick();
    check_eq("cont_stop_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a gate.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (499) tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_cnt", {22'd0, cnt}, 32'd0);
    check_eq("midrst_fword", fword, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    run_gate(lat);
    check_eq("postrst_latency", lat, 32'd1025);
    check_eq("postrst_cnt", {22'd0, cnt}, 32'd16);

    // Triangle 1000..15000 on even samples, garbage on invalid ones.
    mode = 4;
    repeat (20) tick();
    run_gate(lat);
`ifdef PEAK_DETECT_EN
    check_eq("peak_max", {18'd0, pmax}, 32'd15000);
    check_eq("peak_min", {18'd0, pmin}, 32'd1000);
`else
    check_eq("peak_max_off", {18'd0, pmax}, 32'd0);
    check_eq("peak_min_off", {18'd0, pmin}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
